// File: rtl/seg7_pkg.sv
// Shared segment definitions for the seven-segment scan driver:
// segment ordering, hex glyph table and a pure decode function.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  // Segment order on the bus, MSB first: {g,f,e,d,c,b,a}.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  localparam seg_t HEX_LUT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic seg_t hex_decode(input logic [3:0] code);
    return HEX_LUT[code];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to seven-segment decoder, internal polarity (1 = lit).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg_c
);

  assign seg_c = hex_decode(code);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: slot/digit/blink counters,
// double-buffered digit data and registered pin outputs with dead time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYCLES    = 500,
  parameter int unsigned BLINK_FRAMES   = 100,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]        scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic [4*NUM_DIGITS-1:0] codes_sh_q, codes_sh_d;
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic       tick;
  logic       frame_evt;
  logic       dark;
  logic [3:0] cur_code;
  seg_t       dec_seg;

  assign cur_code = codes_sh_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .code  (cur_code),
    .seg_c (dec_seg)
  );

  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    codes_sh_d  = codes_sh_q;
    blank_sh_d  = blank_sh_q;
    blink_sh_d  = blink_sh_q;
    dp_sh_d     = dp_sh_q;
    an_d        = '0;

    tick      = (scan_cnt_q == SCAN_LAST);
    frame_evt = tick && (idx_q == IDX_LAST);

    scan_cnt_d = tick ? '0 : scan_cnt_q + CNT_W'(1);
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_evt) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    if (load) begin
      codes_sh_d = codes;
      blank_sh_d = blank;
      blink_sh_d = blink;
      dp_sh_d    = dp;
    end

    // Outputs are built from the pre-edge shadow so a load shows one edge later.
    dark     = !en || blank_sh_q[idx_q] || (blink_sh_q[idx_q] && blink_ph_q);
    seg_d    = (dark ? '0 : SEG_W'(dec_seg)) ^ SEG_POL;
    dp_out_d = (!dark && dp_sh_q[idx_q]) ^ SEG_ACTIVE_LOW;
    if (en && (scan_cnt_q >= DEAD_END)) begin
      an_d[idx_q] = 1'b1;
    end
    an_d    = an_d ^ AN_POL;
    frame_d = frame_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      codes_sh_q  <= '0;
      blank_sh_q  <= '1;
      blink_sh_q  <= '0;
      dp_sh_q     <= '0;
      seg_q       <= SEG_POL;
      dp_out_q    <= SEG_ACTIVE_LOW;
      an_q        <= AN_POL;
      frame_q     <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      codes_sh_q  <= codes_sh_d;
      blank_sh_q  <= blank_sh_d;
      blink_sh_q  <= blink_sh_d;
      dp_sh_q     <= dp_sh_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg    = seg_q;
  assign dp_out = dp_out_q;
  assign an     = an_q;
  assign frame  = frame_q;

endmodule
